// File: rtl/sobel_edge_detect_pkg.sv
// sobel_edge_detect_pkg: shared output levels, gradient widths and tap-sum helper
package sobel_edge_detect_pkg;
    localparam logic [7:0] EDGE_VAL       = 8'hFF;
    localparam logic [7:0] BG_VAL         = 8'h00;
    localparam int         SUM_W          = 10;
    localparam int         G_W            = 11;
    localparam logic [7:0] THRESH_RST_DEF = 8'd64;

    // a + 2*b + c; max 1020 so 10 bits never wrap
    function automatic logic [SUM_W-1:0] tap_sum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction
endpackage

// File: rtl/sobel_edge_detect_abs_diff.sv
// sobel_abs_diff: registered absolute difference of two unsigned gradient sums
module sobel_abs_diff
    import sobel_edge_detect_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SUM_W-1:0] a,
    input  logic [SUM_W-1:0] b,
    output logic [SUM_W-1:0] y
);
    always_ff @(posedge clk) begin
        if (!rst_n) y <= '0;
        else        y <= (a > b) ? a - b : b - a;
    end
endmodule

// File: rtl/sobel_edge_detect.sv
// sobel_edge_detect: 3-stage Sobel magnitude threshold with per-frame edge-pixel count
module sobel_edge_detect
    import sobel_edge_detect_pkg::*;
#(
    parameter logic [7:0] THRESH_RST = THRESH_RST_DEF,
    parameter int         CNT_W      = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             matrix_vs,
    input  logic             matrix_hs,
    input  logic             matrix_de,
    input  logic [7:0]       matrix_p11,
    input  logic [7:0]       matrix_p12,
    input  logic [7:0]       matrix_p13,
    input  logic [7:0]       matrix_p21,
    input  logic [7:0]       matrix_p22,
    input  logic [7:0]       matrix_p23,
    input  logic [7:0]       matrix_p31,
    input  logic [7:0]       matrix_p32,
    input  logic [7:0]       matrix_p33,
    input  logic [7:0]       threshold,
    output logic             post_vs,
    output logic             post_hs,
    output logic             post_de,
    output logic [7:0]       post_y,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             edge_cnt_vld
);
    logic [SUM_W-1:0] gxp, gxn, gyp, gyn, gx, gy;
    logic [G_W-1:0]   g;
    logic [2:0]       vs_sr, hs_sr, de_sr;
    logic [7:0]       thr_q;
    logic             vs_q, post_vs_q;
    logic [CNT_W-1:0] acc, acc_next;
    logic             edge_hit, count_hit, frame_end;
    logic             unused_p22;

    assign unused_p22 = ^matrix_p22;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gxp <= '0;
            gxn <= '0;
            gyp <= '0;
            gyn <= '0;
        end else begin
            gxp <= tap_sum(matrix_p13, matrix_p23, matrix_p33);
            gxn <= tap_sum(matrix_p11, matrix_p21, matrix_p31);
            gyp <= tap_sum(matrix_p31, matrix_p32, matrix_p33);
            gyn <= tap_sum(matrix_p11, matrix_p12, matrix_p13);
        end
    end

    sobel_abs_diff u_gx (.clk(clk), .rst_n(rst_n), .a(gxp), .b(gxn), .y(gx));
    sobel_abs_diff u_gy (.clk(clk), .rst_n(rst_n), .a(gyp), .b(gyn), .y(gy));

    // de_sr[1] is the enable aligned with the stage-2 magnitudes
    assign g         = {1'b0, gx} + {1'b0, gy};
    assign edge_hit  = de_sr[1] && (g > {3'b000, thr_q});
    assign count_hit = post_de && (post_y == EDGE_VAL);
    assign acc_next  = (count_hit && acc != {CNT_W{1'b1}}) ? acc + CNT_W'(1) : acc;
    assign frame_end = post_vs && !post_vs_q;
    assign post_vs   = vs_sr[2];
    assign post_hs   = hs_sr[2];
    assign post_de   = de_sr[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_sr        <= '0;
            hs_sr        <= '0;
            de_sr        <= '0;
            post_y       <= BG_VAL;
            thr_q        <= THRESH_RST;
            vs_q         <= 1'b0;
            post_vs_q    <= 1'b0;
            acc          <= '0;
            edge_cnt     <= '0;
            edge_cnt_vld <= 1'b0;
        end else begin
            vs_sr        <= {vs_sr[1:0], matrix_vs};
            hs_sr        <= {hs_sr[1:0], matrix_hs};
            de_sr        <= {de_sr[1:0], matrix_de};
            post_y       <= edge_hit ? EDGE_VAL : BG_VAL;
            vs_q         <= matrix_vs;
            post_vs_q    <= post_vs;
            edge_cnt_vld <= frame_end;
            if (matrix_vs && !vs_q) thr_q <= threshold;
            // this cycle's increment still lands in the reported count
            if (frame_end) begin
                edge_cnt <= acc_next;
                acc      <= '0;
            end else begin
                acc      <= acc_next;
            end
        end
    end
endmodule

// File: doc/sobel_edge_detect.md
SOBEL_EDGE_DETECT -- requirements
Module: sobel_edge_detect

Interface
REQ-001 SHALL have parameter THRESH_RST, default 8'd64: threshold loaded at reset.
REQ-002 SHALL have parameter CNT_W, default 22: edge-counter width (1920x1080 fits).
REQ-003 SHALL have ports clk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have ports rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports matrix_vs / matrix_hs / matrix_de  in  1 each  syncs from the 3x3 window stage.
REQ-006 SHALL have ports matrix_p11..matrix_p33  in  8 each  window pixels; row 1 oldest line, column 3 newest pixel.
REQ-007 SHALL have ports threshold  in  8  edge threshold request, frame-synchronous.
REQ-008 SHALL have ports post_vs / post_hs / post_de  out  1 each  syncs delayed to match post_y.
REQ-009 SHALL have ports post_y  out  8  8'hFF for edge, 8'h00 otherwise.
REQ-010 SHALL have ports edge_cnt  out  CNT_W  edge-pixel count of the last completed frame.
REQ-011 SHALL have ports edge_cnt_vld  out  1  one-cycle strobe when edge_cnt updates.

Function
REQ-012 SHALL be a 3-stage pipeline; post_* sync outputs equal matrix_* inputs delayed exactly 3 clocks.
REQ-013 Stage 1 SHALL register 10-bit sums: GXP=p13+2*p23+p33, GXN=p11+2*p21+p31, GYP=p31+2*p32+p33, GYN=p11+2*p12+p13.
REQ-014 Stage 2 SHALL register |Gx|=|GXP-GXN| and |Gy|=|GYP-GYN|, each 10-bit unsigned (max 1020), no wrap.
REQ-015 Stage 3 SHALL compute G=|Gx|+|Gy| at 11 bits (max 2040) and drive post_y=8'hFF when G > thr_q zero-extended, else 8'h00.
REQ-016 post_y SHALL be 8'h00 whenever post_de is 0, regardless of G.
REQ-017 thr_q SHALL load threshold only on a matrix_vs rising edge (0->1); mid-frame threshold changes SHALL NOT affect the current frame.
REQ-018 Accumulator SHALL increment by 1 on each cycle with post_de=1 and post_y=8'hFF; SHALL saturate at 2^CNT_W-1.
REQ-019 On a post_vs rising edge: edge_cnt <= accumulator (including any increment in that cycle), edge_cnt_vld=1 for that one cycle, accumulator cleared to 0 in the same cycle.
REQ-020 edge_cnt SHALL hold its value between strobes; the first strobe after reset SHALL report pixels counted since reset.
REQ-021 Block SHALL have no stall/backpressure; one pixel per clock accepted continuously.

Reset
REQ-022 With rst_n=0 at a clock edge: all pipeline registers, post_vs/hs/de, post_y, edge_cnt, edge_cnt_vld, accumulator SHALL be 0; thr_q SHALL be THRESH_RST; sync-edge detectors SHALL be 0.
REQ-023 Reset asserted mid-frame SHALL take effect on the next edge; after release, outputs SHALL be valid 3 clocks after valid matrix_* inputs resume.

Structure
REQ-024 A shared package SHALL hold EDGE_VAL (8'hFF), BG_VAL (8'h00), the 10/11-bit gradient widths and the default THRESH_RST.
REQ-025 One sub-module sobel_abs_diff (two 10-bit unsigned in, registered 10-bit absolute difference out) SHALL be instantiated twice in stage 2; all other logic SHALL be flat.

Verification
REQ-026 All p=8'h80, de=1, threshold=64 -> G=0, post_y=8'h00 three clocks after each input.
REQ-027 p11=p21=p31=0, other p=255, threshold=64 -> |Gx|=1020, |Gy|=0, G=1020, post_y=8'hFF at cycle+3; all-255 window -> 8'h00.
REQ-028 Frame with G exactly 100 and thr_q=100 -> post_y=8'h00; G=101 -> 8'hFF (strict greater-than).
REQ-029 threshold changed 64->255 mid-frame with vertical-step input -> post_y stays 8'hFF until next matrix_vs rise, then 8'h00.
REQ-030 Frame with exactly 10 edge pixels -> at next post_vs rise edge_cnt=10, edge_cnt_vld high exactly 1 cycle, the following frame counts from 0.
REQ-031 rst_n=0 for 1 cycle mid-line -> next cycle all outputs 0, thr_q=64; post_de returns 3 clocks after matrix_de resumes.
